// File: rtl/display_7seg_multiplexado_pkg.sv
// display_pkg: shared constants and the hex-to-segment encoding for the
// multiplexed 7-segment display back end.
//   CATODOS_APAGADO : all segments off (active-low cathodes)
//   hex_a_7seg      : nibble -> active-low segments, bit 0 = a .. bit 6 = g
package display_pkg;

  localparam logic [6:0] CATODOS_APAGADO = 7'b1111111;

  function automatic logic [6:0] hex_a_7seg(input logic [3:0] i_hex);
    logic [6:0] r_seg;
    case (i_hex)
      4'h0: r_seg = 7'b1000000;
      4'h1: r_seg = 7'b1111001;
      4'h2: r_seg = 7'b0100100;
      4'h3: r_seg = 7'b0110000;
      4'h4: r_seg = 7'b0011001;
      4'h5: r_seg = 7'b0010010;
      4'h6: r_seg = 7'b0000010;
      4'h7: r_seg = 7'b1111000;
      4'h8: r_seg = 7'b0000000;
      4'h9: r_seg = 7'b0010000;
      4'hA: r_seg = 7'b0001000;
      4'hB: r_seg = 7'b0000011;
      4'hC: r_seg = 7'b1000110;
      4'hD: r_seg = 7'b0100001;
      4'hE: r_seg = 7'b0000110;
      default: r_seg = 7'b0001110;
    endcase
    return r_seg;
  endfunction

endpackage

// File: rtl/decodificador_hex_7seg.sv
// decodificador_hex_7seg: combinational hex nibble to 7-segment decoder.
//   i_nibble  in  4  hex digit
//   o_catodos out 7  active-low segments, bit 0 = a .. bit 6 = g
module decodificador_hex_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_catodos
);

  assign o_catodos = hex_a_7seg(i_nibble);

endmodule

// File: rtl/display_7seg_multiplexado.sv
// display_7seg_multiplexado: time-multiplexed driver for an N-digit
// common-anode 7-segment bank with frame-coherent double buffering,
// per-digit enables, leading-zero suppression and per-slot ghost blanking.
//   clk              in  1            system clock
//   reset            in  1            async, active-high
//   datos            in  4*N_DIGITOS  hex nibbles, digit 0 rightmost
//   cargar           in  1            capture datos into shadow
//   habilitar_dig    in  N_DIGITOS    per-digit enable (live)
//   supresion_ceros  in  1            leading-zero blanking (live)
//   anodo            out N_DIGITOS    active-low digit select, one-cold or all ones
//   catodos          out 7            active-low segments
//   pendiente        out 1            shadow waiting for next frame start
module display_7seg_multiplexado
  import display_pkg::*;
#(
  parameter int N_DIGITOS    = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CICLOS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*N_DIGITOS-1:0] datos,
  input  logic                   cargar,
  input  logic [N_DIGITOS-1:0]   habilitar_dig,
  input  logic                   supresion_ceros,
  output logic [N_DIGITOS-1:0]   anodo,
  output logic [6:0]             catodos,
  output logic                   pendiente
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  logic [CW-1:0]                 r_cnt;
  logic [IW-1:0]                 r_idx;
  logic [N_DIGITOS-1:0][3:0]     r_shadow;
  logic [N_DIGITOS-1:0][3:0]     r_visible;
  logic                          r_pendiente;
  logic [N_DIGITOS-1:0]          r_anodo;
  logic [6:0]                    r_catodos;

  logic                          w_tick;
  logic                          w_wrap;
  logic                          w_lit;
  logic [N_DIGITOS-1:0]          w_supr;
  logic [N_DIGITOS-1:0][6:0]     w_seg;

  assign w_tick = (r_cnt == CW'(PRESCALE - 1));
  assign w_wrap = w_tick && (r_idx == IW'(N_DIGITOS - 1));

  // Prescaler and scan index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= (r_idx == IW'(N_DIGITOS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // Double buffer. A load coinciding with the transfer tick still lands in
  // shadow and keeps pendiente set; visible takes the old shadow value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_visible   <= '0;
      r_pendiente <= 1'b0;
    end else begin
      if (w_wrap && r_pendiente) r_visible <= r_shadow;
      if (cargar) begin
        r_shadow    <= datos;
        r_pendiente <= 1'b1;
      end else if (w_wrap) begin
        r_pendiente <= 1'b0;
      end
    end
  end

  // Suppression mask: a digit is blanked when it and every nibble above it
  // are zero. Digit 0 always shows so a zero value reads "0".
  always_comb begin
    logic w_acc;
    w_acc  = 1'b0;
    w_supr = '0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      w_acc     = w_acc | (|r_visible[i]);
      w_supr[i] = supresion_ceros && !w_acc && (i != 0);
    end
  end

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_dec
    decodificador_hex_7seg u_dec (
      .i_nibble  (r_visible[g]),
      .o_catodos (w_seg[g])
    );
  end

  assign w_lit = (r_cnt >= CW'(BLANK_CICLOS)) && habilitar_dig[r_idx] && !w_supr[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anodo   <= '1;
      r_catodos <= CATODOS_APAGADO;
    end else if (w_lit) begin
      r_anodo   <= ~(N_DIGITOS'(1) << r_idx);
      r_catodos <= w_seg[r_idx];
    end else begin
      r_anodo   <= '1;
      r_catodos <= CATODOS_APAGADO;
    end
  end

  assign anodo     = r_anodo;
  assign catodos   = r_catodos;
  assign pendiente = r_pendiente;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
module tb_display_7seg_multiplexado;

  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 1;
  localparam int FRAME = N * P;

  typedef struct {
    logic [15:0]      dat;
    logic [3:0]       hab;
    logic             supr;
    logic [3:0][3:0]  an;   // expected anodo in lit cycles of each slot
    logic [3:0][6:0]  cat;  // expected catodos in lit cycles of each slot
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] datos = '0;
  logic        cargar = 1'b0;
  logic [3:0]  habilitar_dig = 4'hF;
  logic        supresion_ceros = 1'b0;
  logic [3:0]  anodo;
  logic [6:0]  catodos;
  logic        pendiente;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;

  display_7seg_multiplexado #(.N_DIGITOS(N), .PRESCALE(P), .BLANK_CICLOS(B)) dut (
    .clk             (clk),
    .reset           (reset),
    .datos           (datos),
    .cargar          (cargar),
    .habilitar_dig   (habilitar_dig),
    .supresion_ceros (supresion_ceros),
    .anodo           (anodo),
    .catodos         (catodos),
    .pendiente       (pendiente)
  );

  always #5 clk = ~clk;

  // At most one anode low, every cycle
  always @(negedge clk) begin
    n_chk++;
    if ($countones(~anodo) > 1) begin
      n_fail++;
      $display("FAIL one_cold_anodo: got %b required at most one zero", anodo);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // k-th negedge after reset release shows the state of slot position (k-1)%FRAME
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic align(input int p);
    for (int i = 0; i < FRAME + 4 && ((k - 1) % FRAME) != p; i++) step();
  endtask

  task automatic check_slots(input int from, input int to, input logic [3:0][3:0] an,
                             input logic [3:0][6:0] cat, input string tag);
    logic [3:0] ea;
    logic [6:0] ec;
    align(from);
    for (int p = from; p <= to; p++) begin
      if ((p % P) < B) begin
        ea = 4'b1111;
        ec = 7'b1111111;
      end else begin
        ea = an[p / P];
        ec = cat[p / P];
      end
      chk($sformatf("%s anodo pos%0d", tag, p), 32'(anodo), 32'(ea));
      chk($sformatf("%s catodos pos%0d", tag, p), 32'(catodos), 32'(ec));
      if (p < to) step();
    end
  endtask

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  vec_t tbl [7];
  vec_t prev;

  initial begin
    tbl[0] = '{16'h12AF, 4'hF, 1'b0, AN_ALL,
               {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    tbl[1] = '{16'h0070, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}};
    tbl[2] = '{16'h0000, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    tbl[3] = '{16'h8888, 4'b0101, 1'b0, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
               {7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000}};
    tbl[4] = '{16'h0070, 4'hF, 1'b0, AN_ALL,
               {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
    tbl[5] = '{16'h3E09, 4'hF, 1'b1, AN_ALL,
               {7'b0110000, 7'b0000110, 7'b1000000, 7'b0010000}};
    tbl[6] = '{16'h06B5, 4'hF, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111111, 7'b0000010, 7'b0000011, 7'b0010010}};
    prev   = '{16'h0000, 4'hF, 1'b0, AN_ALL,
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("por anodo", 32'(anodo), 32'h0F);
    chk("por catodos", 32'(catodos), 32'h7F);
    chk("por pendiente", 32'(pendiente), 32'h0);
    reset = 1'b0;
    k = 0;

    // Get nonzero data visible and a second load pending, then reset mid-slot
    align(5);
    datos = 16'h0009; cargar = 1'b1; step(); cargar = 1'b0;
    align(1);
    chk("pre-reset anodo", 32'(anodo), 32'b1110);
    chk("pre-reset catodos", 32'(catodos), 32'b0010000);
    align(6);
    datos = 16'h0001; cargar = 1'b1; step(); cargar = 1'b0;
    chk("pre-reset pendiente", 32'(pendiente), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset anodo", 32'(anodo), 32'h0F);
    chk("async reset catodos", 32'(catodos), 32'h7F);
    chk("async reset pendiente", 32'(pendiente), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    step();
    chk("post-reset dark slot0 anodo", 32'(anodo), 32'h0F);
    step();
    chk("post-reset slot0 anodo", 32'(anodo), 32'b1110);
    chk("post-reset visible cleared", 32'(catodos), 32'b1000000);
    chk("post-reset pendiente", 32'(pendiente), 32'h0);

    // Table: load mid-frame, old frame stays coherent, new frame shows entry
    for (int i = 0; i < 7; i++) begin
      align(5);
      datos = tbl[i].dat; cargar = 1'b1; step(); cargar = 1'b0;
      chk($sformatf("v%0d pendiente set", i), 32'(pendiente), 32'h1);
      check_slots(6, FRAME - 1, prev.an, prev.cat, $sformatf("v%0d old", i));
      habilitar_dig = tbl[i].hab;
      supresion_ceros = tbl[i].supr;
      step();
      chk($sformatf("v%0d pendiente clear", i), 32'(pendiente), 32'h0);
      check_slots(0, FRAME - 1, tbl[i].an, tbl[i].cat, $sformatf("v%0d new", i));
      prev = tbl[i];
    end

    // Load on the exact transfer tick while another value is pending
    align(5);
    datos = 16'h0003; cargar = 1'b1; step(); cargar = 1'b0;
    align(FRAME - 2);
    datos = 16'h0005; cargar = 1'b1; step(); cargar = 1'b0;
    chk("simul pendiente held", 32'(pendiente), 32'h1);
    habilitar_dig = 4'hF;
    supresion_ceros = 1'b0;
    step();
    chk("simul pendiente frame1", 32'(pendiente), 32'h1);
    check_slots(0, FRAME - 1, AN_ALL,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000}, "simul 0003");
    step();
    chk("simul pendiente frame2", 32'(pendiente), 32'h0);
    check_slots(0, FRAME - 1, AN_ALL,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}, "simul 0005");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
